// File: rtl/dcache_line_fetcher_pkg.sv
// Shared types and constants for the dcache line fetcher.
package dcache_line_fetcher_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int LINE_BYTES       = 16;
    localparam int LINE_WIDTH       = 8 * LINE_BYTES;
    localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

    typedef logic [LINE_WIDTH-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RF_REQ  = 3'd3,
        RF_WAIT = 3'd4,
        RESP    = 3'd5
    } line_fetch_state_e;

    // Clears the byte-offset bits so the address names a whole line.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_fetcher.sv
// Data cache line fetcher: optional dirty-victim writeback, then line refill.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a miss command
// WB_REQ  | victim write request held on the memory port until gnt
// WB_WAIT | waiting for the write acknowledge (rvalid)
// RF_REQ  | refill read request held on the memory port until gnt
// RF_WAIT | waiting for read data (rvalid)
// RESP    | one-cycle fill pulse to the controller
module dcache_line_fetcher
    import dcache_line_fetcher_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  evict_dirty_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  line_t                 evict_data_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output line_t                 fill_data_o,
    output logic                  busy_o,
    output logic                  protocol_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output line_t                 mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  line_t                 mem_rdata_i
);

    line_fetch_state_e     state_q, state_d;
    logic                  capture;
    logic                  rvalid_in_wait;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic [ADDR_WIDTH-1:0] evict_addr_q;
    line_t                 evict_data_q;
    line_t                 fill_data_q;
    logic                  protocol_err_q;

    assign rvalid_in_wait = (state_q == WB_WAIT) || (state_q == RF_WAIT);

    // Next-state decode; capture flags acceptance of a miss command.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_valid_i) begin
                    capture = 1'b1;
                    state_d = evict_dirty_i ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ:  if (mem_gnt_i)    state_d = WB_WAIT;
            WB_WAIT: if (mem_rvalid_i) state_d = RF_REQ;
            RF_REQ:  if (mem_gnt_i)    state_d = RF_WAIT;
            RF_WAIT: if (mem_rvalid_i) state_d = RESP;
            RESP:                      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Command capture; addresses are stored line-aligned.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
        end else if (capture) begin
            miss_addr_q  <= line_align(miss_addr_i);
            evict_addr_q <= line_align(evict_addr_i);
            evict_data_q <= evict_data_i;
        end
    end

    // Refill data holds until the next refill completes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                    fill_data_q <= '0;
        else if (state_q == RF_WAIT && mem_rvalid_i)   fill_data_q <= mem_rdata_i;
    end

    // Sticky flag for a response arriving when nothing is outstanding.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                               protocol_err_q <= 1'b0;
        else if (mem_rvalid_i && !rvalid_in_wait) protocol_err_q <= 1'b1;
    end

    // Moore outputs: only state and registers feed the ports.
    assign miss_ready_o   = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign mem_req_o      = (state_q == WB_REQ) || (state_q == RF_REQ);
    assign mem_we_o       = (state_q == WB_REQ);
    assign mem_addr_o     = (state_q == WB_REQ) ? evict_addr_q :
                            (state_q == RF_REQ) ? miss_addr_q  : '0;
    assign mem_wdata_o    = (state_q == WB_REQ) ? evict_data_q : '0;
    assign fill_valid_o   = (state_q == RESP);
    assign fill_addr_o    = (state_q == RESP) ? miss_addr_q : '0;
    assign fill_data_o    = fill_data_q;
    assign protocol_err_o = protocol_err_q;

endmodule
